fetch_pc_predictor: RTL and testbench

- Owns the fetch PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- In IF it predicts the next PC for the instruction being fetched.
- In EX it consumes the resolved branch/jump outcome produced by the branch comparator, together with the computed target and the predicted next PC carried down the pipe.
- On a mismatch it raises a flush and redirects fetch. It sits between the EX-stage branch resolution and the IF stage.

---
 rtl/fetch_pc_predictor.sv | 96 +++++++++
 tb/tb_fetch_pc_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_predictor.sv
// Fetch PC register with a direct-mapped BTB (2-bit saturating counters).
// Predicts the next PC in IF and redirects fetch when EX resolution disagrees.
module fetch_pc_predictor #(
    parameter int unsigned BTB_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_npc,
    input  logic        ex_valid,
    input  logic        ex_is_ctrl,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pred_npc,
    output logic        flush,
    output logic [31:0] redirect_pc
);
    localparam int unsigned IDX = $clog2(BTB_ENTRIES);
    localparam int unsigned TW  = 30 - IDX;

    logic [31:0]            r_pc;
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [1:0]             r_ctr    [BTB_ENTRIES];
    logic [TW-1:0]          r_tag    [BTB_ENTRIES];
    logic [31:0]            r_target [BTB_ENTRIES];

    logic [IDX-1:0] w_if_idx;
    logic [IDX-1:0] w_ex_idx;
    logic [TW-1:0]  w_if_tag;
    logic [TW-1:0]  w_ex_tag;
    logic           w_if_hit;
    logic           w_ex_hit;
    logic           w_upd;
    logic           w_flush;
    logic [31:0]    w_actual_npc;

    assign w_if_idx = r_pc[IDX+1:2];
    assign w_if_tag = r_pc[31:IDX+2];
    assign w_ex_idx = ex_pc[IDX+1:2];
    assign w_ex_tag = ex_pc[31:IDX+2];

    // Lookup reads the pre-edge arrays, so a same-cycle update is seen next cycle.
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign if_pred_taken = w_if_hit && r_ctr[w_if_idx][1];
    assign if_pred_npc   = if_pred_taken ? r_target[w_if_idx] : r_pc + 32'd4;
    assign if_pc         = r_pc;

    assign w_actual_npc = (ex_is_ctrl && ex_taken) ? ex_target : ex_pc + 32'd4;
    assign w_flush      = ex_valid && (w_actual_npc != ex_pred_npc);
    assign flush        = w_flush;
    assign redirect_pc  = w_actual_npc;

    assign w_upd    = ex_valid && ex_is_ctrl;
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_flush) begin
            r_pc <= w_actual_npc;
        end else if (!stall) begin
            r_pc <= if_pred_npc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_ctr   <= '{default: 2'b01};
        end else if (w_upd) begin
            if (w_ex_hit) begin
                if (ex_taken) begin
                    if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                end else begin
                    if (r_ctr[w_ex_idx] != 2'b00) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                r_valid[w_ex_idx] <= 1'b1;
                r_ctr[w_ex_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target need no reset: valid bits gate every hit. A taken resolve
    // writes both whether it refreshes a hit or replaces an aliased entry.
    always_ff @(posedge clk) begin
        if (w_upd && ex_taken) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
        end
    end
endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_fetch_pc_predictor;
    logic        clk = 1'b0;
    logic        rst, stall;
    logic        ex_valid, ex_is_ctrl, ex_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_npc;
    logic [31:0] if_pc, if_pred_npc, redirect_pc;
    logic        if_pred_taken, flush;

    int n_checks = 0;
    int n_errors = 0;
    string       q_name[$];
    logic [31:0] q_exp[$];

    always #5 clk = ~clk;

    fetch_pc_predictor #(.BTB_ENTRIES(64), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_npc(if_pred_npc),
        .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_npc(ex_pred_npc),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string name, input logic [31:0] v);
        q_name.push_back(name);
        q_exp.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       name;
        logic [31:0] exp;
        n_checks++;
        if (q_exp.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed %h required <queued value>", obs);
        end else begin
            name = q_name.pop_front();
            exp  = q_exp.pop_front();
            assert (obs === exp) else begin
                n_errors++;
                $error("FAIL %s: observed %h required %h", name, obs, exp);
            end
        end
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        expect_val(name, exp);
        observe(if_pc);
    endtask

    task automatic look(input string name, input logic exp_t, input logic [31:0] exp_npc);
        expect_val({name, "_taken"}, 32'(exp_t));
        expect_val({name, "_npc"}, exp_npc);
        observe(32'(if_pred_taken));
        observe(if_pred_npc);
    endtask

    task automatic tick();
        @(negedge clk);
        ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_taken = 1'b0;
        #1;
    endtask

    task automatic resolve(input string name, input logic ctrl, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pred,
                           input logic exp_flush, input logic [31:0] exp_redir);
        ex_valid = 1'b1; ex_is_ctrl = ctrl; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_pred_npc = pred;
        expect_val({name, "_flush"}, 32'(exp_flush));
        if (exp_flush) expect_val({name, "_redirect"}, exp_redir);
        #1;
        observe(32'(flush));
        if (exp_flush) observe(redirect_pc);
    endtask

    // Steer fetch to addr using a non-control mispredict in EX (no BTB update).
    task automatic jump_to(input logic [31:0] addr);
        tick();
        resolve("jump", 1'b0, 1'b0, addr - 32'd4, 32'h0, ~addr, 1'b1, addr);
        tick();
        chk_pc("jump_pc", addr);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_taken = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_npc = '0;

        @(negedge clk); #1;
        chk_pc("rst_pc", 32'h0);
        look("rst", 1'b0, 32'h4);
        expect_val("rst_flush", 32'd0);
        observe(32'(flush));

        @(negedge clk); rst = 1'b0; #1;
        chk_pc("seq0", 32'h0);
        tick(); chk_pc("seq4", 32'h4); look("seq4", 1'b0, 32'h8);
        tick(); chk_pc("seq8", 32'h8); look("seq8", 1'b0, 32'hC);
        tick(); chk_pc("seqC", 32'hC);
        tick(); chk_pc("seq10", 32'h10);

        // Allocate 0x10 while it is being looked up in the same cycle.
        resolve("alloc", 1'b1, 1'b1, 32'h10, 32'h40, 32'h14, 1'b1, 32'h40);
        look("rbw", 1'b0, 32'h14);
        tick(); chk_pc("redir40", 32'h40);
        jump_to(32'h10); look("alloc_hit", 1'b1, 32'h40);

        resolve("nt1", 1'b1, 1'b0, 32'h10, 32'h40, 32'h40, 1'b1, 32'h14);
        look("nt1_pre", 1'b1, 32'h40);
        tick(); chk_pc("nt1_pc", 32'h14);
        resolve("nt2", 1'b1, 1'b0, 32'h10, 32'h40, 32'h40, 1'b1, 32'h14);
        tick();
        resolve("nt3", 1'b1, 1'b0, 32'h10, 32'h40, 32'h40, 1'b1, 32'h14);
        tick();
        resolve("t_from0", 1'b1, 1'b1, 32'h10, 32'h40, 32'h40, 1'b0, 32'h0);
        jump_to(32'h10); look("ctr01", 1'b0, 32'h14);

        resolve("t2", 1'b1, 1'b1, 32'h10, 32'h40, 32'h14, 1'b1, 32'h40);
        tick();
        resolve("t3", 1'b1, 1'b1, 32'h10, 32'h40, 32'h40, 1'b0, 32'h0);
        tick();
        resolve("t4", 1'b1, 1'b1, 32'h10, 32'h40, 32'h40, 1'b0, 32'h0);
        tick();
        resolve("nt_sat", 1'b1, 1'b0, 32'h10, 32'h40, 32'h14, 1'b0, 32'h0);
        jump_to(32'h10); look("ctr_sat", 1'b1, 32'h40);

        tick(); stall = 1'b1;
        resolve("stall_mp", 1'b1, 1'b1, 32'h20, 32'h80, 32'h24, 1'b1, 32'h80);
        tick(); chk_pc("stall_redir", 32'h80);
        tick(); chk_pc("stall_hold1", 32'h80);
        tick(); chk_pc("stall_hold2", 32'h80);
        tick(); chk_pc("stall_hold3", 32'h80);
        stall = 1'b0;
        tick(); chk_pc("unstall", 32'h84);

        jump_to(32'h110); look("alias_miss", 1'b0, 32'h114);
        resolve("alias_alloc", 1'b1, 1'b1, 32'h110, 32'h200, 32'h114, 1'b1, 32'h200);
        tick(); chk_pc("alias_redir", 32'h200);
        jump_to(32'h10);  look("alias_evicted", 1'b0, 32'h14);
        jump_to(32'h110); look("alias_hit", 1'b1, 32'h200);

        @(negedge clk); rst = 1'b1; #1;
        chk_pc("midrst_pc", 32'h0);
        look("midrst", 1'b0, 32'h4);
        tick(); rst = 1'b0;
        jump_to(32'h110); look("post_rst_110", 1'b0, 32'h114);
        jump_to(32'h20);  look("post_rst_20", 1'b0, 32'h24);

        n_checks++;
        assert (q_exp.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain: observed %0d required 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
